// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier, IEEE-754 style, flush-to-zero, round-to-nearest-even.
// Three stages: S1 unpack/classify/multiply, S2 normalise, S3 round/pack/flags (output register).
// All stages advance together when the output slot is empty or being drained.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_a, i_b, i_vld       operands {sign, exp, man} and their valid
//   o_rdy                 operands accepted this cycle when i_vld is high
//   o_res, o_res_vld      product and its valid
//   i_res_rdy             downstream accepts the result
//   exception             Inf/NaN result from Inf/NaN operand or invalid operation
//   overflow, underflow   finite operands saturated to Inf / flushed to zero
//   invalid               0 x Inf, or a NaN operand
module fp_mult_pipe #(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10,
   localparam int unsigned W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_vld,
   output logic         o_rdy,
   output logic [W-1:0] o_res,
   output logic         o_res_vld,
   input  logic         i_res_rdy,
   output logic         exception,
   output logic         overflow,
   output logic         underflow,
   output logic         invalid
);

   localparam int unsigned ProdW = 2 * MAN_W + 2;
   // Exponent arithmetic carries two extra bits: one for sum headroom, one for sign.
   localparam int unsigned ExpW2 = EXP_W + 2;
   localparam logic [EXP_W-1:0] ExpOnes = '1;
   localparam logic [ExpW2-1:0] Bias = ExpW2'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [ExpW2-1:0] ExpMax = ExpW2'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNan = {1'b0, ExpOnes, 1'b1, {(MAN_W - 1){1'b0}}};

   logic adv;

   // ---------------- S1: unpack, classify, multiply ----------------
   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_man, b_man;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
   logic             s1_spec_d, s1_exc_d, s1_inv_d;
   logic [W-1:0]     s1_spec_res_d;

   logic             s1_vld_q, s1_sign_q, s1_spec_q, s1_exc_q, s1_inv_q;
   logic [W-1:0]     s1_spec_res_q;
   logic [ProdW-1:0] s1_prod_q;
   logic [ExpW2-1:0] s1_exp_q;

   assign a_sign = i_a[W-1];
   assign b_sign = i_b[W-1];
   assign a_exp  = i_a[W-2 -: EXP_W];
   assign b_exp  = i_b[W-2 -: EXP_W];
   assign a_man  = i_a[MAN_W-1:0];
   assign b_man  = i_b[MAN_W-1:0];
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (a_exp == ExpOnes) && (a_man == '0);
   assign b_inf  = (b_exp == ExpOnes) && (b_man == '0);
   assign a_nan  = (a_exp == ExpOnes) && (a_man != '0);
   assign b_nan  = (b_exp == ExpOnes) && (b_man != '0);
   assign sign   = a_sign ^ b_sign;

   // Special cases resolved up front; the checks are in priority order.
   always_comb begin
      s1_spec_d     = 1'b1;
      s1_exc_d      = 1'b0;
      s1_inv_d      = 1'b0;
      s1_spec_res_d = '0;
      if (a_nan || b_nan || (a_zero && b_inf) || (b_zero && a_inf)) begin
         s1_spec_res_d = QNan;
         s1_exc_d      = 1'b1;
         s1_inv_d      = 1'b1;
      end else if (a_inf || b_inf) begin
         s1_spec_res_d = {sign, ExpOnes, {MAN_W{1'b0}}};
         s1_exc_d      = 1'b1;
      end else if (a_zero || b_zero) begin
         s1_spec_res_d = {sign, {(W - 1){1'b0}}};
      end else begin
         s1_spec_d = 1'b0;
      end
   end

   // ---------------- S2: normalise, guard/sticky ----------------
   logic             norm_hi;
   logic [ProdW-2:0] prod_n;
   logic [MAN_W-1:0] frac;
   logic             guard, sticky;

   logic             s2_vld_q, s2_sign_q, s2_spec_q, s2_exc_q, s2_inv_q;
   logic [W-1:0]     s2_spec_res_q;
   logic [MAN_W-1:0] s2_frac_q;
   logic             s2_guard_q, s2_sticky_q;
   logic [ExpW2-1:0] s2_exp_q;

   // Product of two [1,2) significands lies in [1,4); the MSB decides the extra exponent bit.
   // prod_n drops the leading one, so the fraction sits directly under its top.
   assign norm_hi = s1_prod_q[ProdW-1];
   assign prod_n  = norm_hi ? s1_prod_q[ProdW-2:0] : {s1_prod_q[ProdW-3:0], 1'b0};
   assign frac    = prod_n[ProdW-2 -: MAN_W];
   assign guard   = prod_n[MAN_W];
   assign sticky  = |prod_n[MAN_W-1:0];

   // ---------------- S3: round, pack, flags ----------------
   logic             inc, carry;
   logic [MAN_W:0]   man_r;
   logic [ExpW2-1:0] exp_r;
   logic [W-1:0]     res_d;
   logic             exc_d, ovf_d, unf_d, inv_d;

   logic [W-1:0]     res_q;
   logic             res_vld_q, exc_q, ovf_q, unf_q, inv_q;

   assign inc   = s2_guard_q & (s2_sticky_q | s2_frac_q[0]);
   assign man_r = {1'b0, s2_frac_q} + (MAN_W + 1)'(inc);
   assign carry = man_r[MAN_W];
   assign exp_r = s2_exp_q + ExpW2'(carry);

   // Empty slots load zeros so result and flags read clear whenever o_res_vld is low.
   always_comb begin
      res_d = '0;
      exc_d = 1'b0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inv_d = 1'b0;
      if (s2_vld_q) begin
         if (s2_spec_q) begin
            res_d = s2_spec_res_q;
            exc_d = s2_exc_q;
            inv_d = s2_inv_q;
         end else if ($signed(exp_r) >= ExpMax) begin
            res_d = {s2_sign_q, ExpOnes, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
         end else if (exp_r[ExpW2-1] || (exp_r == '0)) begin
            res_d = {s2_sign_q, {(W - 1){1'b0}}};
            unf_d = 1'b1;
         end else begin
            // On a rounding carry the low bits of man_r are already zero.
            res_d = {s2_sign_q, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
         end
      end
   end

   // ---------------- Pipeline registers ----------------
   assign adv   = !res_vld_q || i_res_rdy;
   assign o_rdy = adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q      <= 1'b0;
         s1_sign_q     <= 1'b0;
         s1_spec_q     <= 1'b0;
         s1_exc_q      <= 1'b0;
         s1_inv_q      <= 1'b0;
         s1_spec_res_q <= '0;
         s1_prod_q     <= '0;
         s1_exp_q      <= '0;
         s2_vld_q      <= 1'b0;
         s2_sign_q     <= 1'b0;
         s2_spec_q     <= 1'b0;
         s2_exc_q      <= 1'b0;
         s2_inv_q      <= 1'b0;
         s2_spec_res_q <= '0;
         s2_frac_q     <= '0;
         s2_guard_q    <= 1'b0;
         s2_sticky_q   <= 1'b0;
         s2_exp_q      <= '0;
         res_q         <= '0;
         res_vld_q     <= 1'b0;
         exc_q         <= 1'b0;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
         inv_q         <= 1'b0;
      end else if (adv) begin
         s1_vld_q      <= i_vld;
         s1_sign_q     <= sign;
         s1_spec_q     <= s1_spec_d;
         s1_exc_q      <= s1_exc_d;
         s1_inv_q      <= s1_inv_d;
         s1_spec_res_q <= s1_spec_res_d;
         s1_prod_q     <= ProdW'({1'b1, a_man}) * ProdW'({1'b1, b_man});
         s1_exp_q      <= {2'b00, a_exp} + {2'b00, b_exp} - Bias;
         s2_vld_q      <= s1_vld_q;
         s2_sign_q     <= s1_sign_q;
         s2_spec_q     <= s1_spec_q;
         s2_exc_q      <= s1_exc_q;
         s2_inv_q      <= s1_inv_q;
         s2_spec_res_q <= s1_spec_res_q;
         s2_frac_q     <= frac;
         s2_guard_q    <= guard;
         s2_sticky_q   <= sticky;
         s2_exp_q      <= s1_exp_q + ExpW2'(norm_hi);
         res_q         <= res_d;
         res_vld_q     <= s2_vld_q;
         exc_q         <= exc_d;
         ovf_q         <= ovf_d;
         unf_q         <= unf_d;
         inv_q         <= inv_d;
      end
   end

   assign o_res     = res_q;
   assign o_res_vld = res_vld_q;
   assign exception = exc_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign invalid   = inv_q;

endmodule
